// File: rtl/mem_arbiter_2m.sv
// mem_arbiter_2m: two-master request/done arbiter in front of a single-port word RAM.
// One memory cycle per grant: IDLE -> ISSUE (strobe) -> RESP (done + read data).
module mem_arbiter_2m #(
  parameter int ADDR_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  output logic [31:0]       m0_rdata,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic [31:0]       m1_rdata,
  output logic              m1_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata,
  output logic              owner,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t            state_q;
  logic              owner_q, rstrb_q, done0_q, done1_q, win_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        mask_q, wmask_q, mask_d;
  // owner resets to 1 so round-robin hands the first tie to master 0
  assign win_d  = (m0_req && m1_req) ? (FIXED_PRIO ? 1'b0 : !owner_q) : m1_req;
  assign mask_d = win_d ? m1_wmask : m0_wmask;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wmask_q <= '0;
      rstrb_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (m0_req || m1_req) begin
          owner_q <= win_d;
          addr_q  <= win_d ? m1_addr : m0_addr;
          wdata_q <= win_d ? m1_wdata : m0_wdata;
          mask_q  <= mask_d;
          wmask_q <= mask_d;
          rstrb_q <= (mask_d == 4'b0000);
          state_q <= ISSUE;
        end
        ISSUE: begin
          rstrb_q <= 1'b0;
          wmask_q <= '0;
          done0_q <= !owner_q;
          done1_q <= owner_q;
          state_q <= RESP;
        end
        RESP: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign mem_rstrb = rstrb_q;
  assign m0_done   = done0_q;
  assign m1_done   = done1_q;
  assign m0_rdata  = (done0_q && mask_q == 4'b0000) ? mem_rdata : 32'h0;
  assign m1_rdata  = (done1_q && mask_q == 4'b0000) ? mem_rdata : 32'h0;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
endmodule
